// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   N_DEFAULT : default operand width
//   S_IDLE / S_CALC / S_DONE : 2-bit FSM state encodings used by seq_divider
package div_pkg;

    localparam int N_DEFAULT = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/div_datapath.sv
// Datapath of the restoring divider: partial remainder R, quotient/dividend
// shift register Q, divisor register D, and the (N+1)-bit subtractor with
// the shift/restore multiplexer.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   load                  : capture R=0, Q=dividend, D=divisor
//   step                  : perform one shift/subtract/restore iteration
//   dividend, divisor     : operands (sampled only on load)
//   quo_next, rem_next    : Q and R as they will be after the current step
module div_datapath
    import div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quo_next,
    output logic [N-1:0] rem_next
);

    logic [N-1:0] r_q;
    logic [N-1:0] q_q;
    logic [N-1:0] d_q;
    logic [N:0]   rq_sh;
    logic [N:0]   diff;

    // R never exceeds the dividend bits shifted in so far, so before the shift
    // its MSB is always 0 and the shifted value fits the N+1-bit subtractor;
    // bit N of the difference is then the borrow, i.e. the restore decision.
    always_comb begin
        rq_sh    = {r_q, q_q[N-1]};
        diff     = rq_sh - {1'b0, d_q};
        quo_next = {q_q[N-2:0], ~diff[N]};
        rem_next = diff[N] ? rq_sh[N-1:0] : diff[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else if (load) begin
            r_q <= '0;
            q_q <= dividend;
            d_q <= divisor;
        end else if (step) begin
            r_q <= rem_next;
            q_q <= quo_next;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: N-bit unsigned dividend / divisor giving an
// N-bit quotient and remainder, one quotient bit per clock.
// Start/done handshake; the controller (FSM, iteration counter, result
// registers) lives here, the arithmetic lives in div_datapath.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : division request, honoured only in IDLE
//   dividend, divisor     : operands, captured on the accepted start
//   quotient, remainder   : registered results, held until the next result
//   busy                  : high while iterating
//   done                  : one-cycle result-valid pulse
//   div_by_zero           : set with done when the divisor was zero
// Build option: define DIV_ZERO_CHECK_EN to short-cut division by zero
// (IDLE -> DONE in one cycle, div_by_zero flagged). Without it a zero divisor
// runs the normal algorithm and div_by_zero is tied low.
//
// state  | meaning
// -------+---------------------------------------------------
// S_IDLE | waiting for start; operands captured on start
// S_CALC | one restoring iteration per cycle, N cycles total
// S_DONE | result registers valid, done pulsed for one cycle
module seq_divider
    import div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          last_step;
    logic [N-1:0]  quo_next;
    logic [N-1:0]  rem_next;

    div_datapath #(.N(N)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .dividend (dividend),
        .divisor  (divisor),
        .quo_next (quo_next),
        .rem_next (rem_next)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_CHECK_EN
                    state_next = (divisor == '0) ? S_DONE : S_CALC;
`else
                    state_next = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (cnt == CNT_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // output / control decode
    always_comb begin
        busy      = (state == S_CALC);
        done      = (state == S_DONE);
        load      = (state == S_IDLE) && start;
        step      = (state == S_CALC);
        last_step = step && (cnt == CNT_LAST);
    end

    // The result registers take the datapath's post-step values on the final
    // iteration edge, so they are valid in the same cycle that done rises.
`ifdef DIV_ZERO_CHECK_EN
    logic dz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz_q      <= 1'b0;
        end else begin
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            if (last_step) begin
                quotient  <= quo_next;
                remainder <= rem_next;
                dz_q      <= 1'b0;
            end else if (load && (divisor == '0)) begin
                quotient  <= '1;
                remainder <= dividend;
                dz_q      <= 1'b1;
            end
        end
    end

    assign div_by_zero = dz_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end
            if (last_step) begin
                quotient  <= quo_next;
                remainder <= rem_next;
            end
        end
    end

    assign div_by_zero = 1'b0;
`endif

endmodule
